// File: rtl/vgg_pkg.sv
// vgg_pkg: shared definitions for the VGG16 feature-map datapath.
//   PIX_W    - default pixel width
//   MAX_W    - widest pixel the generic max helper can handle
//   pool_ok  - legal pooling window size check (2..4)
//   pix_max  - signed/unsigned maximum of two zero-padded pixels
package vgg_pkg;

    localparam int PIX_W = 32;
    localparam int MAX_W = 64;

    function automatic bit pool_ok(input int pool);
        return (pool >= 2) && (pool <= 4);
    endfunction

    // Operands are zero-padded to MAX_W; w is the real pixel width.
    // A signed compare is an unsigned compare with the sign bit inverted.
    function automatic logic [MAX_W-1:0] pix_max(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input bit               sgn,
                                                 input int               w);
        logic [MAX_W-1:0] flip;
        flip = sgn ? (MAX_W'(1) << (w - 1)) : '0;
        return ((a ^ flip) >= (b ^ flip)) ? a : b;
    endfunction

endpackage

// File: rtl/max_tree.sv
// max_tree: combinational maximum of N pixels.
//   taps_i - N packed pixels
//   max_o  - largest pixel (signed or unsigned compare per SIGNED)
module max_tree
    import vgg_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int N          = 4,
    parameter bit SIGNED     = 1'b1
) (
    input  logic [N-1:0][DATA_WIDTH-1:0] taps_i,
    output logic [DATA_WIDTH-1:0]        max_o
);

    logic [DATA_WIDTH-1:0] acc;

    always_comb begin
        acc = taps_i[0];
        for (int i = 1; i < N; i++) begin
            acc = DATA_WIDTH'(pix_max(MAX_W'(acc), MAX_W'(taps_i[i]), SIGNED, DATA_WIDTH));
        end
    end

    assign max_o = acc;

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming POOLxPOOL max-pooling with stride POOL.
//   clk, rst   - clock, asynchronous active-high reset
//   valid_in   - i_data accepted this cycle (raster order, no backpressure)
//   i_data     - input pixel
//   o_valid    - one-cycle pulse per pooled window
//   o_data     - window maximum, held until the next window
//   o_last     - with o_valid on the final window of a frame
module maxpool_stream
    import vgg_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int WIDTH      = 5,
    parameter int HEIGHT     = 5,
    parameter int POOL       = 2,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    localparam int D     = (POOL - 1) * WIDTH + POOL;
    localparam int NT    = POOL * POOL;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);
    localparam int COL_N = (WIDTH / POOL) * POOL;   // columns covered by windows
    localparam int ROW_N = (HEIGHT / POOL) * POOL;  // rows covered by windows

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIN  = CW'(COL_N - 1);
    localparam logic [RW-1:0] ROW_FIN  = RW'(ROW_N - 1);
    localparam logic [1:0]    PH_LAST  = 2'(POOL - 1);

    if (!pool_ok(POOL) || WIDTH < POOL || HEIGHT < POOL || DATA_WIDTH > MAX_W) begin : g_bad_cfg
        $error("maxpool_stream: illegal POOL/WIDTH/HEIGHT/DATA_WIDTH");
    end

    // Post-shift slot 0 is always the live i_data, so only D-1 registers
    // are stored; stored index k holds post-shift index k+1.
    logic [D-2:0][DATA_WIDTH-1:0] lb_q;

    always_ff @(posedge clk) begin
        if (valid_in) lb_q <= {lb_q[D-3:0], i_data};
    end

    logic [NT-1:0][DATA_WIDTH-1:0] taps;

    for (genvar r = 0; r < POOL; r++) begin : g_row
        for (genvar c = 0; c < POOL; c++) begin : g_col
            if (r == 0 && c == 0) begin : g_live
                assign taps[0] = i_data;
            end else begin : g_buf
                assign taps[r*POOL+c] = lb_q[r*WIDTH+c-1];
            end
        end
    end

    logic [DATA_WIDTH-1:0] win_max;

    max_tree #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (NT),
        .SIGNED    (SIGNED)
    ) u_max (
        .taps_i(taps),
        .max_o (win_max)
    );

    // Position counters plus position-within-window phases, so the
    // stride test needs no modulo.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    cph_q, cph_d, rph_q, rph_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cph_d = cph_q;
        rph_d = rph_q;
        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                cph_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    rph_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    rph_d = (rph_q == PH_LAST) ? 2'd0 : rph_q + 2'd1;
                end
            end else begin
                col_d = col_q + 1'b1;
                cph_d = (cph_q == PH_LAST) ? 2'd0 : cph_q + 2'd1;
            end
        end
    end

    // Remainder columns/rows beyond the last full window never fire.
    logic col_ok, row_ok;

    if (WIDTH % POOL == 0) begin : g_col_all
        assign col_ok = 1'b1;
    end else begin : g_col_rem
        assign col_ok = (col_q < CW'(COL_N));
    end

    if (HEIGHT % POOL == 0) begin : g_row_all
        assign row_ok = 1'b1;
    end else begin : g_row_rem
        assign row_ok = (row_q < RW'(ROW_N));
    end

    logic fire, at_fin;

    assign fire   = valid_in && (cph_q == PH_LAST) && (rph_q == PH_LAST) && col_ok && row_ok;
    assign at_fin = (col_q == COL_FIN) && (row_q == ROW_FIN);

    logic                  o_valid_q, o_last_q;
    logic [DATA_WIDTH-1:0] o_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            cph_q     <= '0;
            rph_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            cph_q     <= cph_d;
            rph_q     <= rph_d;
            o_valid_q <= fire;
            o_last_q  <= fire && at_fin;
            if (fire) o_data_q <= win_max;
        end
    end

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic [31:0] din;
    int          sel;
    logic [4:0]  v_i, ov, ol;
    logic [31:0] od [5];

    always #5 clk = ~clk;

    // per-instance geometry: {WIDTH, HEIGHT, POOL, SIGNED}
    localparam int PW [5] = '{4, 5, 2, 2, 6};
    localparam int PH [5] = '{4, 5, 2, 2, 3};
    localparam int PP [5] = '{2, 2, 2, 2, 3};
    localparam bit PS [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    for (genvar k = 0; k < 5; k++) begin : g_vin
        assign v_i[k] = vin && (sel == k);
    end

    maxpool_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4), .POOL(2), .SIGNED(1'b1)) u0 (
        .clk(clk), .rst(rst), .valid_in(v_i[0]), .i_data(din),
        .o_valid(ov[0]), .o_data(od[0]), .o_last(ol[0]));
    maxpool_stream #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5), .POOL(2), .SIGNED(1'b0)) u1 (
        .clk(clk), .rst(rst), .valid_in(v_i[1]), .i_data(din),
        .o_valid(ov[1]), .o_data(od[1]), .o_last(ol[1]));
    maxpool_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2), .POOL(2), .SIGNED(1'b1)) u2 (
        .clk(clk), .rst(rst), .valid_in(v_i[2]), .i_data(din),
        .o_valid(ov[2]), .o_data(od[2]), .o_last(ol[2]));
    maxpool_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2), .POOL(2), .SIGNED(1'b0)) u3 (
        .clk(clk), .rst(rst), .valid_in(v_i[3]), .i_data(din),
        .o_valid(ov[3]), .o_data(od[3]), .o_last(ol[3]));
    maxpool_stream #(.DATA_WIDTH(32), .WIDTH(6), .HEIGHT(3), .POOL(3), .SIGNED(1'b1)) u4 (
        .clk(clk), .rst(rst), .valid_in(v_i[4]), .i_data(din),
        .o_valid(ov[4]), .o_data(od[4]), .o_last(ol[4]));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] frame_q [$];
    logic [31:0] cap_q   [$];

    // Reference: pixel idx of the stream (frames start at (0,0), back to back).
    function automatic void model(input int inst, input int idx,
                                  output bit f, output logic [31:0] m, output bit l);
        int W, H, P, base, p, r, c;
        logic [31:0] v;
        W = PW[inst]; H = PH[inst]; P = PP[inst];
        base = (idx / (W * H)) * W * H;
        p = idx % (W * H);
        r = p / W;
        c = p % W;
        f = (r % P == P - 1) && (c % P == P - 1) && (c < (W / P) * P) && (r < (H / P) * P);
        l = f && (r == (H / P) * P - 1) && (c == (W / P) * P - 1);
        m = '0;
        if (f) begin
            m = frame_q[base + r * W + c];
            for (int i = 0; i < P; i++)
                for (int j = 0; j < P; j++) begin
                    v = frame_q[base + (r - i) * W + (c - j)];
                    if (PS[inst] ? ($signed(v) > $signed(m)) : (v > m)) m = v;
                end
        end
    endfunction

    // Streams frame_q into one instance, checking every cycle's outputs.
    task automatic run_frame(input int inst, input int maxgap, input string nm);
        bit          f, l;
        logic [31:0] m;
        int          ng;
        sel = inst;
        cap_q.delete();
        for (int idx = 0; idx < frame_q.size(); idx++) begin
            ng = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < ng; g++) begin
                vin = 1'b0;
                din = $urandom;
                @(negedge clk);
                n_cmp++;
                if (ov[inst] !== 1'b0 || ol[inst] !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s gap idx=%0d: o_valid=%b o_last=%b, required 0/0", nm, idx, ov[inst], ol[inst]);
                end
            end
            model(inst, idx, f, m, l);
            vin = 1'b1;
            din = frame_q[idx];
            @(negedge clk);
            n_cmp++;
            if (ov[inst] !== f) begin
                n_err++;
                $display("FAIL %s o_valid idx=%0d: got %b, required %b", nm, idx, ov[inst], f);
            end
            n_cmp++;
            if (ol[inst] !== l) begin
                n_err++;
                $display("FAIL %s o_last idx=%0d: got %b, required %b", nm, idx, ol[inst], l);
            end
            if (f) begin
                n_cmp++;
                if (od[inst] !== m) begin
                    n_err++;
                    $display("FAIL %s o_data idx=%0d: got %h, required %h", nm, idx, od[inst], m);
                end
            end
            if (ov[inst] === 1'b1) cap_q.push_back(od[inst]);
        end
        vin = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ov[inst] !== 1'b0) begin
            n_err++;
            $display("FAIL %s trailing o_valid: got %b, required 0", nm, ov[inst]);
        end
    endtask

    task automatic fill_ramp(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(32'(i));
    endtask

    task automatic fill_rand(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        sel = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0 || ol[k] !== 1'b0 || od[k] !== 32'h0) begin
                n_err++;
                $display("FAIL reset inst%0d: v=%b l=%b d=%h, required 0/0/0", k, ov[k], ol[k], od[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_raster;
        logic [31:0] exp_q [$] = '{32'd5, 32'd7, 32'd13, 32'd15};
        fill_ramp(16);
        run_frame(0, 0, "raster4x4");
        n_cmp++;
        if (cap_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL raster4x4 count: got %0d, required %0d", cap_q.size(), exp_q.size());
        end else
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL raster4x4 out%0d: got %0d, required %0d", i, cap_q[i], exp_q[i]);
                end
            end
    endtask

    task automatic test_remainder;
        logic [31:0] exp_q [$] = '{32'd6, 32'd8, 32'd16, 32'd18};
        fill_ramp(25);
        run_frame(1, 0, "rem5x5");
        n_cmp++;
        if (cap_q.size() != 4 || cap_q[0] !== exp_q[0] || cap_q[1] !== exp_q[1] ||
            cap_q[2] !== exp_q[2] || cap_q[3] !== exp_q[3]) begin
            n_err++;
            $display("FAIL rem5x5 outputs: got %p, required %p", cap_q, exp_q);
        end
    endtask

    task automatic test_signed;
        frame_q = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFD};
        run_frame(2, 0, "neg_signed");
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL neg_signed: got %p, required ffffffff", cap_q);
        end
        run_frame(3, 0, "neg_unsigned");
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL neg_unsigned: got %p, required ffffffff", cap_q);
        end
        // mixed signs: the two compare modes disagree here
        frame_q = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1};
        run_frame(2, 0, "mix_signed");
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0] !== 32'd5) begin
            n_err++;
            $display("FAIL mix_signed: got %p, required 5", cap_q);
        end
        run_frame(3, 0, "mix_unsigned");
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0] !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL mix_unsigned: got %p, required fffffffd", cap_q);
        end
    endtask

    task automatic test_pool3;
        fill_ramp(18);
        run_frame(4, 0, "pool3");
        n_cmp++;
        if (cap_q.size() != 2 || cap_q[0] !== 32'd14 || cap_q[1] !== 32'd17) begin
            n_err++;
            $display("FAIL pool3 outputs: got %p, required 14,17", cap_q);
        end
    endtask

    task automatic test_gaps;
        fill_ramp(16);
        run_frame(0, 3, "gaps4x4");
        n_cmp++;
        if (cap_q.size() != 4 || cap_q[0] !== 32'd5 || cap_q[1] !== 32'd7 ||
            cap_q[2] !== 32'd13 || cap_q[3] !== 32'd15) begin
            n_err++;
            $display("FAIL gaps4x4 outputs: got %p, required 5,7,13,15", cap_q);
        end
    endtask

    task automatic test_back_to_back;
        fill_rand(32);
        run_frame(0, 0, "b2b_4x4");
        fill_rand(50);
        run_frame(1, 2, "b2b_5x5_gaps");
        fill_rand(36);
        run_frame(4, 1, "b2b_pool3");
        fill_rand(12);
        run_frame(2, 1, "b2b_2x2s");
        fill_rand(12);
        run_frame(3, 0, "b2b_2x2u");
    endtask

    task automatic test_reset_midframe;
        fill_ramp(6);
        run_frame(0, 0, "pre_reset");
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ov[0] !== 1'b0 || ol[0] !== 1'b0 || od[0] !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: v=%b l=%b d=%h, required 0/0/0", ov[0], ol[0], od[0]);
        end
        for (int i = 0; i < 3; i++) begin
            vin = 1'b1;
            din = $urandom;
            @(negedge clk);
            n_cmp++;
            if (ov[0] !== 1'b0) begin
                n_err++;
                $display("FAIL in_reset cyc%0d: o_valid=%b, required 0", i, ov[0]);
            end
        end
        vin = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        fill_ramp(16);
        run_frame(0, 0, "post_reset");
        n_cmp++;
        if (cap_q.size() != 4 || cap_q[0] !== 32'd5 || cap_q[1] !== 32'd7 ||
            cap_q[2] !== 32'd13 || cap_q[3] !== 32'd15) begin
            n_err++;
            $display("FAIL post_reset outputs: got %p, required 5,7,13,15", cap_q);
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_remainder();
        test_signed();
        test_pool3();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming max-pooling unit for the VGG16 feature-map datapath. It accepts one pixel per valid cycle in raster order and buffers POOL-1 lines plus POOL pixels in a shift-register line buffer. At each stride-aligned window position it emits the maximum of the POOL×POOL window. It replaces the fixed 2×2 tap-only line buffer: window size, frame geometry and signedness are parametrised, the compare is done internally, and output valid/last framing is added.

## Interface
- DATA_WIDTH, 32: pixel width in bits.
- WIDTH, 5: feature-map width in pixels, at least POOL.
- HEIGHT, 5: feature-map height in rows, at least POOL.
- POOL, 2: window size and stride. Legal range 2..4.
- SIGNED, 1: 1 = two's-complement compare, 0 = unsigned compare.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  i_data is accepted this cycle.
- i_data  in  DATA_WIDTH  input pixel.
- o_valid  out  1  one-cycle pulse; o_data holds a window maximum.
- o_data  out  DATA_WIDTH  pooled pixel.
- o_last  out  1  asserted with o_valid on the final output of a frame.

## Operation
- One clock domain (clk). Reset is asynchronous and active-high.
- While rst is high: col_cnt=0, row_cnt=0, o_valid=0, o_last=0, o_data=0.
- Line buffer contents are not reset and are never read before being rewritten in the current frame.
- Line buffer is a shift register of depth D=(POOL-1)*WIDTH+POOL. It shifts only on valid_in; index 0 receives i_data.
- On a valid cycle, the incoming pixel is at (row_cnt, col_cnt). Window tap (r,c), with r,c in 0..POOL-1, is pixel (row_cnt-r, col_cnt-c) and is read from index r*WIDTH+c after the shift. Equivalently, the tap is i_data for r=c=0, else the pre-shift index r*WIDTH+c-1.
- A window fires when all of these hold:
  - valid_in=1
  - col_cnt mod POOL = POOL-1
  - row_cnt mod POOL = POOL-1
  - col_cnt < (WIDTH/POOL)*POOL
  - row_cnt < (HEIGHT/POOL)*POOL
- Remainder columns and rows (WIDTH or HEIGHT not a multiple of POOL) are consumed but produce no output.
- Maximum: reduction over POOL² taps using signed or unsigned comparison per SIGNED. Equal values: either operand; the result is identical.
- Counters advance per valid_in: col_cnt wraps at WIDTH-1 and increments row_cnt. row_cnt wraps at HEIGHT-1 to 0, so back-to-back frames need no gap.
- o_last=1 on the firing window at row (HEIGHT/POOL)*POOL-1 and column (WIDTH/POOL)*POOL-1.
- No backpressure. Downstream must accept every o_valid pulse.

## Timing
- Latency: o_valid/o_data/o_last are registered and appear 1 cycle after the valid_in edge that completes the window.
- Throughput: 1 pixel/cycle. Output rate is at most 1 per POOL input cycles.
- Gaps in valid_in freeze the buffer and counters. Window contents and outputs are unaffected by gap length.
- o_valid is high for exactly one cycle per window. o_data holds its value until the next firing; o_data is don't-care when o_valid=0.
- Reset mid-frame: outputs clear immediately (asynchronous). The next valid_in after release is pixel (0,0) of a new frame, and no output mixes pre- and post-reset pixels.
- Simultaneous last pixel of frame N and wrap: the firing for frame N and the counter wrap occur on the same edge. The next pixel is (0,0) of frame N+1.

## Structure
- Shared package `vgg_pkg`: pixel width constant, the POOL legal-range check, and a signed/unsigned max function.
- Sub-module `max_tree`: a combinational POOL²-input maximum with a SIGNED parameter, reusable by other pooling variants.
- Top holds the line buffer, counters, fire logic and output registers.
- Elaboration error if POOL is outside 2..4, or if WIDTH<POOL or HEIGHT<POOL.

## Test plan
- WIDTH=4, HEIGHT=4, POOL=2, input 0..15 raster, continuous valid -> o_data 5, 7, 13, 15. o_last only with 15. Each output arrives 1 cycle after inputs 5, 7, 13, 15.
- WIDTH=5, HEIGHT=5, POOL=2, input 0..24 -> exactly 4 outputs: 6, 8, 16, 18. Column 4 and row 4 produce nothing. o_last with 18.
- SIGNED=1, WIDTH=HEIGHT=2, input -5, -1, -8, -3 -> output -1. Same stimulus with SIGNED=0 -> output 0xFFFFFFFF (-1 unsigned is the max).
- POOL=3, WIDTH=6, HEIGHT=3, input 0..17 -> outputs 14, 17. o_last with 17.
- Repeat the first case with random 0–3 cycle valid_in gaps -> identical o_data sequence, each 1 cycle after its completing input.
- Assert rst after 6 pixels of the first case, release, then send a full 0..15 frame -> no o_valid during or after reset until 5, 7, 13, 15 appear.
